// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared framebuffer constants, pixel type and fill FSM state type
// Contents:
//   H_RES, V_RES, FB_DEPTH  framebuffer geometry (320x240, linear y*H_RES+x)
//   ADDR_W, DATA_W          framebuffer address / pixel widths
//   pixel_t                 RGB444 pixel
//   fill_state_t            rectangle-fill FSM states
package vga_pkg;

    localparam int H_RES    = 320;
    localparam int V_RES    = 240;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 12;

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/vga_rect_walker.sv
// rtl/vga_rect_walker.sv - raster walker producing framebuffer addresses of a rectangle
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                latch corners and position the walker on (x0, y0)
//   x0, y0, x1, y1      inclusive rectangle corners (already validated)
//   adv                 step to the next pixel in raster order
//   addr                framebuffer address of the current pixel
//   last                current pixel is the bottom-right corner
module vga_rect_walker #(
    parameter int H_RES  = vga_pkg::H_RES,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [8:0]        x0,
    input  logic [7:0]        y0,
    input  logic [8:0]        x1,
    input  logic [7:0]        y1,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    import vga_pkg::*;

    logic [8:0]        cur_x;
    logic [7:0]        cur_y;
    logic [8:0]        x0_q;
    logic [8:0]        x1_q;
    logic [7:0]        y1_q;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] y0_base;

    // Start row offset, evaluated once per fill; for the 320-wide screen this
    // is y*256 + y*64 so no multiplier sits in the address path.
    always_comb begin
        y0_base = '0;
        if (H_RES == 320) begin
            y0_base = (ADDR_W'(y0) << 8) + (ADDR_W'(y0) << 6);
        end else begin
            y0_base = ADDR_W'(32'(y0) * H_RES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x    <= '0;
            cur_y    <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            row_base <= '0;
        end else if (load) begin
            x0_q     <= x0;
            x1_q     <= x1;
            y1_q     <= y1;
            cur_x    <= x0;
            cur_y    <= y0;
            row_base <= y0_base;
        end else if (adv) begin
            if (cur_x < x1_q) begin
                cur_x <= cur_x + 9'd1;
            end else if (cur_y < y1_q) begin
                cur_x    <= x0_q;
                cur_y    <= cur_y + 8'd1;
                row_base <= row_base + ADDR_W'(H_RES);
            end
        end
    end

    assign addr = row_base + ADDR_W'(cur_x);
    assign last = (cur_x == x1_q) && (cur_y == y1_q);

endmodule

// File: rtl/vga_fb_write_arb.sv
// rtl/vga_fb_write_arb.sv - framebuffer write arbiter: CPU pixel writes vs rectangle-fill engine
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_we_i/addr_i/wdata_i       CPU single-pixel write request
//   cpu_ready_o                   CPU write accepted when cpu_we_i & cpu_ready_o
//   fill_start_i, fill_*_i        fill start pulse, inclusive corners, colour
//   fill_busy_o                   fill engine walking the rectangle
//   fill_done_o / fill_err_o      completion / rejected-start pulses
//   fb_we_o/addr_o/wdata_o        registered framebuffer write port
module vga_fb_write_arb #(
    parameter int H_RES      = vga_pkg::H_RES,
    parameter int V_RES      = vga_pkg::V_RES,
    parameter int ADDR_W     = vga_pkg::ADDR_W,
    parameter int DATA_W     = vga_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ready_o,
    input  logic              fill_start_i,
    input  logic [8:0]        fill_x0_i,
    input  logic [7:0]        fill_y0_i,
    input  logic [8:0]        fill_x1_i,
    input  logic [7:0]        fill_y1_i,
    input  logic [DATA_W-1:0] fill_color_i,
    output logic              fill_busy_o,
    output logic              fill_done_o,
    output logic              fill_err_o,
    output logic              fb_we_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [DATA_W-1:0] fb_wdata_o
);
    import vga_pkg::*;

    localparam int FB_SIZE = H_RES * V_RES;
    localparam int SC_W    = $clog2(STARVE_MAX + 1);

    fill_state_t       state;
    logic [SC_W-1:0]   starve_cnt;
    logic [DATA_W-1:0] color_q;
    logic              start_ok;
    logic              load;
    logic              in_fill;
    logic              force_fill;
    logic              cpu_win;
    logic              fill_win;
    logic              cpu_in_range;
    logic [ADDR_W-1:0] walk_addr;
    logic              walk_last;

    assign start_ok = (fill_x0_i <= fill_x1_i) && (32'(fill_x1_i) < H_RES) &&
                      (fill_y0_i <= fill_y1_i) && (32'(fill_y1_i) < V_RES);
    assign load     = (state == IDLE) && fill_start_i && start_ok;
    assign in_fill  = (state == FILL);

    // The CPU keeps priority until it has taken STARVE_MAX back-to-back slots
    // from a pending fill; then it is stalled for exactly one cycle.
    assign force_fill   = in_fill && (starve_cnt == SC_W'(STARVE_MAX));
    assign cpu_ready_o  = !force_fill;
    assign cpu_win      = cpu_we_i && cpu_ready_o;
    assign fill_win     = in_fill && !cpu_win;
    assign cpu_in_range = 32'(cpu_addr_i) < FB_SIZE;

    assign fill_busy_o  = in_fill;

    vga_rect_walker #(
        .H_RES  (H_RES),
        .ADDR_W (ADDR_W)
    ) u_walker (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .x0   (fill_x0_i),
        .y0   (fill_y0_i),
        .x1   (fill_x1_i),
        .y1   (fill_y1_i),
        .adv  (fill_win),
        .addr (walk_addr),
        .last (walk_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (load) state <= FILL;
                FILL:    if (fill_win && walk_last) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_q <= '0;
        end else if (load) begin
            color_q <= fill_color_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !in_fill) begin
            starve_cnt <= '0;
        end else if (cpu_win) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Out-of-range CPU writes complete the handshake but never reach the
    // framebuffer; address/data hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we_o    <= 1'b0;
            fb_addr_o  <= '0;
            fb_wdata_o <= '0;
        end else begin
            fb_we_o <= 1'b0;
            if (cpu_win && cpu_in_range) begin
                fb_we_o    <= 1'b1;
                fb_addr_o  <= cpu_addr_i;
                fb_wdata_o <= cpu_wdata_i;
            end else if (fill_win) begin
                fb_we_o    <= 1'b1;
                fb_addr_o  <= walk_addr;
                fb_wdata_o <= color_q;
            end
        end
    end

    // Done is registered from DONE so it lands the cycle after the last
    // fill pixel is visible on the framebuffer port.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_done_o <= 1'b0;
            fill_err_o  <= 1'b0;
        end else begin
            fill_done_o <= (state == DONE);
            fill_err_o  <= (state == IDLE) && fill_start_i && !start_ok;
        end
    end

endmodule

// File: tb/tb_vga_fb_write_arb.sv
// tb/tb_vga_fb_write_arb.sv - self-checking bench for vga_fb_write_arb
module tb_vga_fb_write_arb;

    localparam int SM = 4;
    localparam int HR = 320;
    localparam int VR = 240;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_we_i = 1'b0;
    logic [16:0] cpu_addr_i = '0;
    logic [11:0] cpu_wdata_i = '0;
    logic        cpu_ready_o;
    logic        fill_start_i = 1'b0;
    logic [8:0]  fill_x0_i = '0;
    logic [7:0]  fill_y0_i = '0;
    logic [8:0]  fill_x1_i = '0;
    logic [7:0]  fill_y1_i = '0;
    logic [11:0] fill_color_i = '0;
    logic        fill_busy_o;
    logic        fill_done_o;
    logic        fill_err_o;
    logic        fb_we_o;
    logic [16:0] fb_addr_o;
    logic [11:0] fb_wdata_o;

    always #5 clk = ~clk;

    vga_fb_write_arb #(.STARVE_MAX(SM)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_ready_o  (cpu_ready_o),
        .fill_start_i (fill_start_i),
        .fill_x0_i    (fill_x0_i),
        .fill_y0_i    (fill_y0_i),
        .fill_x1_i    (fill_x1_i),
        .fill_y1_i    (fill_y1_i),
        .fill_color_i (fill_color_i),
        .fill_busy_o  (fill_busy_o),
        .fill_done_o  (fill_done_o),
        .fill_err_o   (fill_err_o),
        .fb_we_o      (fb_we_o),
        .fb_addr_o    (fb_addr_o),
        .fb_wdata_o   (fb_wdata_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the fill is a queue of addresses in raster order.
    int          m_q[$];
    bit          m_active = 0;
    int          m_starve = 0;
    int          m_cd = 0;
    logic [11:0] m_color = '0;
    logic        exp_we = 0, exp_done = 0, exp_err = 0;
    logic [16:0] exp_addr = '0;
    logic [11:0] exp_data = '0;
    bit          chk_en = 0;
    wire         exp_ready = !(m_active && (m_starve == SM));

    task automatic model_update();
        bit pre_idle;
        bit cwin;
        if (rst) begin
            m_q.delete(); m_active = 0; m_starve = 0; m_cd = 0;
            exp_we = 0; exp_addr = '0; exp_data = '0; exp_done = 0; exp_err = 0;
            return;
        end
        pre_idle = !m_active && (m_cd == 0);
        exp_done = (m_cd == 1);
        if (m_cd > 0) m_cd--;
        exp_err = 0;
        exp_we  = 0;
        cwin = cpu_we_i && !(m_active && m_starve == SM);
        if (cwin) begin
            if (int'(cpu_addr_i) < HR * VR) begin
                exp_we = 1; exp_addr = cpu_addr_i; exp_data = cpu_wdata_i;
            end
            if (m_active) m_starve++;
        end else if (m_active) begin
            exp_we = 1; exp_addr = 17'(m_q.pop_front()); exp_data = m_color; m_starve = 0;
            if (m_q.size() == 0) begin m_active = 0; m_cd = 1; end
        end
        if (pre_idle && fill_start_i) begin
            if (fill_x0_i <= fill_x1_i && int'(fill_x1_i) < HR &&
                fill_y0_i <= fill_y1_i && int'(fill_y1_i) < VR) begin
                for (int y = int'(fill_y0_i); y <= int'(fill_y1_i); y++)
                    for (int x = int'(fill_x0_i); x <= int'(fill_x1_i); x++)
                        m_q.push_back(y * HR + x);
                m_color = fill_color_i; m_active = 1; m_starve = 0;
            end else begin
                exp_err = 1;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cpu_ready_o", cpu_ready_o, exp_ready);
            check("fb_we_o", fb_we_o, exp_we);
            check("fb_addr_o", fb_addr_o, exp_addr);
            check("fb_wdata_o", fb_wdata_o, exp_data);
            check("fill_busy_o", fill_busy_o, m_active);
            check("fill_done_o", fill_done_o, exp_done);
            check("fill_err_o", fill_err_o, exp_err);
        end
    end

    int wr_log[$];
    int busy_cnt = 0, done_cnt = 0, err_cnt = 0, rlow_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (fb_we_o === 1'b1) wr_log.push_back(int'(fb_addr_o));
        if (fill_busy_o === 1'b1) busy_cnt++;
        if (fill_done_o === 1'b1) done_cnt++;
        if (fill_err_o === 1'b1) err_cnt++;
        if (cpu_ready_o === 1'b0) rlow_cnt++;
    end

    task automatic clear_log();
        wr_log.delete(); busy_cnt = 0; done_cnt = 0; err_cnt = 0; rlow_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        cpu_we_i = 0; fill_start_i = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_fill(input int x0, input int y0, input int x1, input int y1, input int col);
        fill_x0_i = 9'(x0); fill_y0_i = 8'(y0); fill_x1_i = 9'(x1); fill_y1_i = 8'(y1);
        fill_color_i = 12'(col); fill_start_i = 1;
        tick();
        fill_start_i = 0;
    endtask

    initial begin
        // reset
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        idle(1);
        check("rst_fb_we", fb_we_o, 0);
        check("rst_busy", fill_busy_o, 0);
        check("rst_ready", cpu_ready_o, 1);

        // CPU write while idle
        cpu_we_i = 1; cpu_addr_i = 17'd1234; cpu_wdata_i = 12'hABC;
        check("cpu_idle_ready", cpu_ready_o, 1);
        tick();
        cpu_we_i = 0;
        check("cpu_we", fb_we_o, 1);
        check("cpu_addr", fb_addr_o, 1234);
        check("cpu_data", fb_wdata_o, 12'hABC);
        idle(2);

        // 2x2 rectangle
        clear_log();
        start_fill(10, 5, 11, 6, 12'hF00);
        idle(10);
        check("rect_nwr", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            check("rect_a0", wr_log[0], 1610);
            check("rect_a1", wr_log[1], 1611);
            check("rect_a2", wr_log[2], 1930);
            check("rect_a3", wr_log[3], 1931);
        end
        check("rect_busy", busy_cnt, 4);
        check("rect_done", done_cnt, 1);

        // rejected starts and out-of-range CPU write
        clear_log();
        start_fill(12, 0, 11, 0, 1); idle(1);
        start_fill(0, 0, 5, 240, 1); idle(1);
        start_fill(0, 0, 320, 0, 1); idle(1);
        cpu_we_i = 1; cpu_addr_i = 17'd76800; cpu_wdata_i = 12'h555;
        tick();
        idle(3);
        check("inv_err", err_cnt, 3);
        check("inv_nwr", wr_log.size(), 0);
        check("inv_busy", busy_cnt, 0);

        // contention: CPU hammering during a 10-pixel fill
        clear_log();
        cpu_we_i = 1; cpu_addr_i = 17'(1000 + $urandom_range(0, 999));
        start_fill(0, 0, 9, 0, 12'h0F0);
        for (int i = 0; i < 60; i++) begin
            cpu_we_i = 1; cpu_addr_i = 17'(1000 + $urandom_range(0, 999));
            cpu_wdata_i = 12'($urandom);
            tick();
        end
        idle(4);
        check("cont_stalls", rlow_cnt, 10);
        check("cont_done", done_cnt, 1);
        begin
            int k;
            k = 0;
            foreach (wr_log[i]) if (wr_log[i] < 10) begin
                check("cont_order", wr_log[i], k);
                k++;
            end
            check("cont_nfill", k, 10);
        end

        // reset in the middle of a fill
        clear_log();
        start_fill(0, 10, 99, 10, 12'h123);
        idle(7);
        rst = 1;
        tick();
        rst = 0;
        check("mid_rst_we", fb_we_o, 0);
        check("mid_rst_busy", fill_busy_o, 0);
        idle(5);
        check("mid_rst_nwr", wr_log.size(), 7);
        check("mid_rst_nodone", done_cnt, 0);
        start_fill(3, 3, 4, 4, 12'h00F);
        idle(8);
        check("after_rst_done", done_cnt, 1);
        check("after_rst_nwr", wr_log.size(), 11);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int x0, y0, x1, y1;
            cpu_we_i    = 1'($urandom_range(0, 1));
            cpu_addr_i  = 17'($urandom_range(0, 79999));
            cpu_wdata_i = 12'($urandom);
            x0 = $urandom_range(0, 329); x1 = x0 + $urandom_range(0, 5);
            y0 = $urandom_range(0, 244); y1 = y0 + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                int t;
                t = x0; x0 = x1; x1 = t;
            end
            fill_x0_i = 9'(x0); fill_x1_i = 9'(x1); fill_y0_i = 8'(y0); fill_y1_i = 8'(y1);
            fill_color_i = 12'($urandom);
            fill_start_i = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0;
        idle(40);

        // full-screen clear
        clear_log();
        start_fill(0, 0, 319, 239, 12'h000);
        for (int i = 0; i < 77000 && done_cnt == 0; i++) tick();
        idle(3);
        check("clear_done", done_cnt, 1);
        check("clear_nwr", wr_log.size(), 76800);
        if (wr_log.size() > 0) begin
            check("clear_first", wr_log[0], 0);
            check("clear_last", wr_log[wr_log.size() - 1], 76799);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_write_arb.md
Name: vga_fb_write_arb

Overview:
- Sole write master for the VGA framebuffer write port (we/addr/wdata, 17-bit address, 12-bit RGB444, 320x240 at address y*320+x).
- Arbitrates between two sources:
  - CPU single-pixel writes.
  - Built-in rectangle-fill engine (screen clear, solid boxes).
- Fill engine generates one pixel write per granted cycle. Fixed CPU priority with a starvation guard keeps the CPU responsive during long fills.

Parameters:
- H_RES, 320, framebuffer width in pixels
- V_RES, 240, framebuffer height in pixels
- ADDR_W, 17, framebuffer address width
- DATA_W, 12, pixel width (RGB444)
- STARVE_MAX, 4, max consecutive CPU grants while the fill is pending before the fill is forced one slot (>=1)

Ports:
- clk  in  1  system clock (same clock as framebuffer write port)
- rst  in  1  synchronous, active-high reset
- cpu_we_i  in  1  CPU write request
- cpu_addr_i  in  ADDR_W  CPU pixel address
- cpu_wdata_i  in  DATA_W  CPU pixel value
- cpu_ready_o  out  1  CPU write accepted this cycle when cpu_we_i & cpu_ready_o
- fill_start_i  in  1  start pulse; coordinates/colour sampled this cycle
- fill_x0_i  in  9  left column, inclusive
- fill_y0_i  in  8  top row, inclusive
- fill_x1_i  in  9  right column, inclusive
- fill_y1_i  in  8  bottom row, inclusive
- fill_color_i  in  DATA_W  fill colour
- fill_busy_o  out  1  fill engine active
- fill_done_o  out  1  one-cycle pulse, fill complete
- fill_err_o  out  1  one-cycle pulse, start rejected (bad coordinates)
- fb_we_o  out  1  framebuffer write enable
- fb_addr_o  out  ADDR_W  framebuffer address
- fb_wdata_o  out  DATA_W  framebuffer data

Behaviour:
- Reset:
  - All outputs 0, except cpu_ready_o = 1 (combinational, see arbitration).
  - FSM returns to IDLE; starvation counter cleared.
  - Reset mid-fill abandons the fill: no done pulse, no further writes. fb_we_o = 0 from the cycle after rst is sampled.
- FSM states:
  - IDLE: fill_start_i = 1 with x0<=x1<H_RES and y0<=y1<V_RES latches x0, x1, y1, colour; sets cur_x = x0, row_base = y0*H_RES, cur_y = y0; goes to FILL; fill_busy_o = 1 next cycle.
  - IDLE, invalid coordinates: fill_err_o pulses next cycle, state stays IDLE, no writes.
  - FILL: each cycle the fill wins the slot, it issues pixel (cur_x, cur_y), then:
    - if cur_x < x1: cur_x++.
    - else if cur_y < y1: cur_x = x0, cur_y++, row_base += H_RES.
    - else: go to DONE.
  - DONE (one cycle): fill_done_o = 1, fill_busy_o = 0, back to IDLE.
  - fill_start_i in FILL or DONE is ignored (no err, no restart).
- Address arithmetic:
  - Fill address = row_base + cur_x, no runtime multiplier. y0*H_RES is computed once at start (shift-add: y*256 + y*64 when H_RES = 320).
  - Max address 76799 fits in ADDR_W.
- Arbitration (per cycle):
  - Fill not in FILL: cpu_ready_o = 1.
  - In FILL: CPU wins if cpu_we_i = 1 and starve_cnt < STARVE_MAX.
    - cpu_ready_o = 0 only when starve_cnt == STARVE_MAX; the fill wins that cycle and starve_cnt resets to 0.
    - A CPU win while FILL increments starve_cnt. A fill win clears it.
  - Fill advances only on cycles it wins.
- CPU out of range: a write with cpu_addr_i >= H_RES*V_RES is accepted (handshake completes) but no fb write is issued.
- Output timing: fb_we_o/fb_addr_o/fb_wdata_o are registered, one cycle after the winning request. fb_we_o = 0 on idle cycles; addr/data hold the last value.
- Done timing: fill_done_o is asserted in the cycle after the last fill pixel appears on fb_*.
- Throughput: uncontended fill writes one pixel per clk. A WxH fill with no CPU traffic takes W*H cycles in FILL.

Decomposition:
- Shared package vga_pkg:
  - constants H_RES, V_RES, FB_DEPTH = H_RES*V_RES, ADDR_W, DATA_W.
  - pixel_t (12-bit RGB444).
  - fill_state_t enum {IDLE, FILL, DONE}.
- One sub-module: vga_rect_walker, containing the cur_x/cur_y/row_base stepping, address output, and the last-pixel flag, advanced by an 'adv' input.
- Arbitration, starvation counter and output registers stay in the top.

Test Plan:
- CPU only, idle: write addr 1234, data 0xABC -> fb_we_o = 1, fb_addr_o = 1234, fb_wdata_o = 0xABC one cycle later; cpu_ready_o stays 1.
- Rect (10,5)-(11,6), colour 0xF00, no CPU -> writes to 1610, 1611, 1930, 1931 on 4 consecutive cycles, then fill_done_o one pulse; busy high exactly 4 cycles.
- Full clear (0,0)-(319,239), colour 0x000 -> 76800 writes, first addr 0, last 76799, single done pulse, no gaps.
- Contention, STARVE_MAX = 4, cpu_we_i held high during a fill -> repeating pattern of 4 CPU writes, 1 fill write with cpu_ready_o = 0 that cycle; fill pixel order unchanged.
- Invalid starts x0 = 12, x1 = 11 and y1 = 240 -> fill_err_o pulse each, no fb writes, busy stays 0. CPU addr 76800 -> accepted, no fb write.
- rst asserted mid-fill after 7 pixels -> fb_we_o = 0 next cycle, busy = 0, no done pulse. A new fill started afterwards completes normally.
